feature_add_pair: RTL and testbench
===================================

# feature_add_pair

Input pairing stage directly upstream of the residual element-wise adder. It takes two independently timed 8-lane feature streams: x1 from the convolution output path and x2 from the shortcut read path. Each stream is buffered in its own FIFO, and the block emits strictly aligned (x1, x2) beat pairs with a single valid strobe, which is the form the adder's shared-valid input expects. A start/done handshake frames each layer by pair count.

## Interface
- FEATURE_WIDTH, `FEATURE_WIDTH, bits per lane; 8 lanes per beat
- FIFO_DEPTH, 16, entries per stream FIFO; power of two, ≥2
- CNT_WIDTH, 16, width of the pair counters
- system_clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start_in  in  1  one-cycle pulse; latches beat_count_in and begins a layer
- beat_count_in  in  CNT_WIDTH  number of pairs in this layer
- busy_out  out  1  high from the cycle after an accepted start until the cycle after done_out
- done_out  out  1  one-cycle pulse with the last output pair
- x1_data_in  in  FEATURE_WIDTH*8  main-path beat
- x1_valid_in  in  1  main-path beat valid
- x1_ready_out  out  1  main-path accept; transfer happens when valid & ready
- x2_data_in  in  FEATURE_WIDTH*8  shortcut beat
- x2_valid_in  in  1  shortcut beat valid
- x2_ready_out  out  1  shortcut accept
- feature_x1_out  out  FEATURE_WIDTH*8  paired x1 beat, to adder x1 input
- feature_x2_out  out  FEATURE_WIDTH*8  paired x2 beat, to adder x2 input
- feature_x_valid_out  out  1  pair valid, to adder valid input; no backpressure

## Operation
- States:
  - IDLE → RUN on start_in when beat_count_in≠0; the count is latched as total.
  - IDLE → DONE on start_in when beat_count_in==0.
  - RUN → DONE when pairs_out reaches total.
  - DONE → IDLE unconditionally.
  - start_in outside IDLE is ignored.
- Counters, all cleared on entering RUN:
  - acc1 counts accepted x1 beats.
  - acc2 counts accepted x2 beats.
  - pairs_out counts emitted pairs.
- Ready rules:
  - x1_ready_out = RUN & !fifo1_full & (acc1 < total). x2 mirrors this with its own FIFO and counter.
  - Surplus beats are never accepted.
- FIFOs:
  - Independent, first-in first-out, no bypass. Data is unmodified, lane order preserved.
  - Occupancy is tracked with wrap-around pointers plus a level counter (0..FIFO_DEPTH).
- Pop rule: both FIFOs pop together in a cycle where both registered levels are nonzero. Otherwise neither pops.
- Push and pop on the same FIFO in the same cycle leaves the level unchanged. This is legal at full, because ready is taken from the registered full flag, and legal at level 1.
- Output registers load the popped heads. feature_x_valid_out is high for exactly the cycles following a pop.
- When valid is low, the data outputs hold their last value.
- done_out is asserted together with the valid of pair number total. With zero count, done_out is asserted in the DONE cycle.

## Timing
- Reset values: feature_x1_out=0, feature_x2_out=0, feature_x_valid_out=0, x1_ready_out=0, x2_ready_out=0, busy_out=0, done_out=0. FIFOs are empty, counters 0, state IDLE.
- Reset mid-layer flushes both FIFOs and discards partial pairs. All outputs take their reset values on the next edge.
- Latency: once both beats of a pair have been accepted (the later one at edge k), feature_x_valid_out is high in the cycle after edge k+1.
- Throughput: one pair per cycle when both streams supply one beat per cycle.
- Maximum skew between the streams is FIFO_DEPTH beats. Beyond that, the leading stream is stalled by ready.
- busy_out drops in the cycle after done_out.

## Configuration
- FEATURE_ADD_PAIR_STATUS_EN
- Defined:
  - Adds outputs x1_level_out and x2_level_out (clog2(FIFO_DEPTH)+1 bits, registered FIFO levels, reset 0).
  - Adds sticky output skew_stall_out: set when either ready is low in RUN while its FIFO is full; cleared on start_in or rst.
- Undefined: these ports and their logic are absent. Core behaviour is identical either way.

## Test plan
- Aligned streams: count=4, both streams valid every cycle with beats 1..4 → 4 consecutive valid pairs with x1==x2 order 1..4; done_out on the 4th; busy_out falls 1 cycle later.
- Skewed streams: count=8, x2 starts 10 cycles after x1 (FIFO_DEPTH=16) → no pair before the first x2 beat is accepted; then 8 pairs, correctly matched by index.
- Overskew: count=32, x1 continuous, x2 withheld → x1_ready_out low after 16 accepts; with STATUS_EN, skew_stall_out=1 and x1_level_out=16. Releasing x2 yields 32 correct pairs.
- Surplus input: count=3, 5 x1 beats offered → only 3 accepted; x1_ready_out stays 0 after the 3rd accept.
- Zero count and ignored start: count=0 → done_out 1 cycle after start, no valid output. A start pulse during RUN does not change total.
- Reset mid-layer: rst after 2 of 6 pairs → next cycle all outputs 0 and FIFOs empty; a fresh start with count=2 produces exactly 2 correct pairs.

Source files
------------

// File: rtl/feature_add_pair.sv
// feature_add_pair: pairs two independently timed 8-lane feature streams
// (x1 main path, x2 shortcut path) into aligned beats for the residual adder.
// Each stream has its own FIFO. A beat pair is emitted only when both FIFOs
// hold data. A start/done handshake frames each layer by its pair count.
//
// Optional build macro FEATURE_ADD_PAIR_STATUS_EN adds FIFO level outputs
// and a sticky skew-stall flag. The core behaviour is identical without it.

`ifndef FEATURE_WIDTH
`define FEATURE_WIDTH 8
`endif

module feature_add_pair #(
    parameter int FEATURE_WIDTH = `FEATURE_WIDTH,
    parameter int FIFO_DEPTH    = 16,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                         system_clk,
    input  logic                         rst,
`ifdef FEATURE_ADD_PAIR_STATUS_EN
    output logic [$clog2(FIFO_DEPTH):0]  x1_level_out,
    output logic [$clog2(FIFO_DEPTH):0]  x2_level_out,
    output logic                         skew_stall_out,
`endif
    input  logic                         start_in,
    input  logic [CNT_WIDTH-1:0]         beat_count_in,
    output logic                         busy_out,
    output logic                         done_out,
    input  logic [FEATURE_WIDTH*8-1:0]   x1_data_in,
    input  logic                         x1_valid_in,
    output logic                         x1_ready_out,
    input  logic [FEATURE_WIDTH*8-1:0]   x2_data_in,
    input  logic                         x2_valid_in,
    output logic                         x2_ready_out,
    output logic [FEATURE_WIDTH*8-1:0]   feature_x1_out,
    output logic [FEATURE_WIDTH*8-1:0]   feature_x2_out,
    output logic                         feature_x_valid_out
);

    localparam int DW = FEATURE_WIDTH * 8;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;
    logic [CNT_WIDTH-1:0]   total_reg;
    logic [CNT_WIDTH-1:0]   pairs_out_reg;
    logic                   busy_reg;
    logic                   done_reg;
    logic                   valid_reg;

    // Per-stream views so both FIFOs come from one generate body.
    // Index 0 is x1, index 1 is x2.
    logic [DW-1:0]          data_s  [2];
    logic [LW-1:0]          level_s [2];
    logic [DW-1:0]          head_s  [2];
    logic [1:0]             valid_s;
    logic [1:0]             ready_s;
    logic [1:0]             full_s;

    logic                   pop;
    logic                   enter_run;
    logic                   last_pair;

    assign data_s[0] = x1_data_in;
    assign data_s[1] = x2_data_in;
    assign valid_s   = {x2_valid_in, x1_valid_in};

    // Both heads leave together only when both registered levels are nonzero,
    // which keeps the two streams locked to the same beat index.
    assign pop       = (level_s[0] != '0) && (level_s[1] != '0);
    assign enter_run = (state_reg == IDLE) && start_in && (beat_count_in != '0);
    assign last_pair = pop && (pairs_out_reg == total_reg - CNT_WIDTH'(1));

    // Next-state decode; start_in outside IDLE is ignored.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start_in) begin
                    state_next = (beat_count_in == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_pair) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Layer FSM with registered busy/done/valid and the pair counter.
    always_ff @(posedge system_clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            total_reg     <= '0;
            pairs_out_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            valid_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next != IDLE);
            // DONE is entered together with the last pair (or straight from
            // IDLE for a zero count), so done lines up with that pair's valid.
            done_reg  <= (state_next == DONE);
            valid_reg <= pop;
            if (enter_run) begin
                total_reg     <= beat_count_in;
                pairs_out_reg <= '0;
            end else if (pop) begin
                pairs_out_reg <= pairs_out_reg + CNT_WIDTH'(1);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_stream
            logic [DW-1:0]        mem [FIFO_DEPTH];
            logic [PW-1:0]        wr_ptr_reg;
            logic [PW-1:0]        rd_ptr_reg;
            logic [LW-1:0]        level_reg;
            logic [CNT_WIDTH-1:0] acc_reg;
            logic [DW-1:0]        head_reg;
            logic                 push;

            // Ready comes from the registered level, so a push while full can
            // never happen, and push+pop at level 1 or full is safe.
            assign full_s[gi]  = (level_reg == LW'(FIFO_DEPTH));
            assign ready_s[gi] = (state_reg == RUN) && !full_s[gi] && (acc_reg < total_reg);
            assign push        = ready_s[gi] && valid_s[gi];
            assign level_s[gi] = level_reg;
            assign head_s[gi]  = head_reg;

            // FIFO storage write port (no reset so it maps onto block RAM).
            always_ff @(posedge system_clk) begin
                if (push) begin
                    mem[wr_ptr_reg] <= data_s[gi];
                end
            end

            // Registered read: the popped head loads the output register and
            // holds while no pop happens.
            always_ff @(posedge system_clk) begin
                if (rst) begin
                    head_reg <= '0;
                end else if (pop) begin
                    head_reg <= mem[rd_ptr_reg];
                end
            end

            // Pointers, level and the accepted-beat counter.
            always_ff @(posedge system_clk) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    level_reg  <= '0;
                    acc_reg    <= '0;
                end else begin
                    if (enter_run) begin
                        acc_reg <= '0;
                    end else if (push) begin
                        acc_reg <= acc_reg + CNT_WIDTH'(1);
                    end
                    if (push) begin
                        wr_ptr_reg <= wr_ptr_reg + PW'(1);
                    end
                    if (pop) begin
                        rd_ptr_reg <= rd_ptr_reg + PW'(1);
                    end
                    case ({push, pop})
                        2'b10:   level_reg <= level_reg + LW'(1);
                        2'b01:   level_reg <= level_reg - LW'(1);
                        default: level_reg <= level_reg;
                    endcase
                end
            end
        end
    endgenerate

    assign x1_ready_out        = ready_s[0];
    assign x2_ready_out        = ready_s[1];
    assign feature_x1_out      = head_s[0];
    assign feature_x2_out      = head_s[1];
    assign feature_x_valid_out = valid_reg;
    assign busy_out            = busy_reg;
    assign done_out            = done_reg;

`ifdef FEATURE_ADD_PAIR_STATUS_EN
    logic skew_stall_reg;

    // Sticky flag: a stream was held off because the other one lagged by a
    // full FIFO. Cleared by any start pulse.
    always_ff @(posedge system_clk) begin
        if (rst || start_in) begin
            skew_stall_reg <= 1'b0;
        end else if ((state_reg == RUN) && (full_s != 2'b00)) begin
            skew_stall_reg <= 1'b1;
        end
    end

    assign skew_stall_out = skew_stall_reg;
    assign x1_level_out   = level_s[0];
    assign x2_level_out   = level_s[1];
`endif

endmodule

// File: tb/tb_feature_add_pair.sv
// Scoreboard bench for feature_add_pair: stimulus pushes expected pairs into
// a queue, a forked monitor pops and compares whenever a pair is presented.
module tb_feature_add_pair;

    localparam int FW    = 8;
    localparam int DW    = FW * 8;
    localparam int DEPTH = 16;
    localparam int CW    = 16;
    localparam int LW    = 5;

    logic           system_clk = 1'b0;
    logic           rst = 1'b1;
    logic           start_in = 1'b0;
    logic [CW-1:0]  beat_count_in = '0;
    logic           busy_out, done_out;
    logic [DW-1:0]  x1_data_in = '0, x2_data_in = '0;
    logic           x1_valid_in = 1'b0, x2_valid_in = 1'b0;
    logic           x1_ready_out, x2_ready_out;
    logic [DW-1:0]  feature_x1_out, feature_x2_out;
    logic           feature_x_valid_out;
`ifdef FEATURE_ADD_PAIR_STATUS_EN
    logic [LW-1:0]  x1_level_out, x2_level_out;
    logic           skew_stall_out;
`endif

    feature_add_pair #(
        .FEATURE_WIDTH(FW),
        .FIFO_DEPTH(DEPTH),
        .CNT_WIDTH(CW)
    ) dut (
        .system_clk(system_clk),
        .rst(rst),
`ifdef FEATURE_ADD_PAIR_STATUS_EN
        .x1_level_out(x1_level_out),
        .x2_level_out(x2_level_out),
        .skew_stall_out(skew_stall_out),
`endif
        .start_in(start_in),
        .beat_count_in(beat_count_in),
        .busy_out(busy_out),
        .done_out(done_out),
        .x1_data_in(x1_data_in),
        .x1_valid_in(x1_valid_in),
        .x1_ready_out(x1_ready_out),
        .x2_data_in(x2_data_in),
        .x2_valid_in(x2_valid_in),
        .x2_ready_out(x2_ready_out),
        .feature_x1_out(feature_x1_out),
        .feature_x2_out(feature_x2_out),
        .feature_x_valid_out(feature_x_valid_out)
    );

    always #5 system_clk = ~system_clk;

    int cyc = 0;
    always @(posedge system_clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          last;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    int            acc1_tb = 0, acc2_tb = 0, rx_count = 0;
    int            fv = -1, lv = -1, start_cyc = 0;
    logic [DW-1:0] first_x1 = '0, first_x2 = '0;
    logic          busy_at_done = 1'b0, busy_after_done = 1'b1, prev_done = 1'b0;
    logic          zero_ok = 1'b0, abort = 1'b0;

    // Lane i of beat v is v+32*i on x1 and 255-v-32*i on x2 (lane order visible).
    function automatic logic [DW-1:0] mk1(input int v);
        logic [DW-1:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = 8'(v + 32 * i);
        return r;
    endfunction

    function automatic logic [DW-1:0] mk2(input int v);
        logic [DW-1:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = 8'(255 - v - 32 * i);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_layer(input int n, input int base);
        exp_t e;
        for (int v = 0; v < n; v++) begin
            e.a = mk1(base + v);
            e.b = mk2(base + v);
            e.last = (v == n - 1);
            sb.push_back(e);
        end
    endtask

    task automatic do_start(input int n);
        @(posedge system_clk); #1;
        start_in = 1'b1;
        beat_count_in = CW'(n);
        @(posedge system_clk); #1;
        start_in = 1'b0;
        start_cyc = cyc;
    endtask

    // Offers n beats on stream s (1 or 2); gives up after bound cycles.
    task automatic drive(input int s, input int n, input int delay, input int base, input int bound);
        int   sent = 0;
        int   used = 0;
        logic took;
        repeat (delay) begin @(posedge system_clk); #1; end
        while (sent < n && used < bound && !abort) begin
            if (s == 1) begin x1_valid_in = 1'b1; x1_data_in = mk1(base + sent); end
            else        begin x2_valid_in = 1'b1; x2_data_in = mk2(base + sent); end
            @(negedge system_clk);
            took = (s == 1) ? x1_ready_out : x2_ready_out;
            @(posedge system_clk); #1;
            used++;
            if (took) sent++;
        end
        if (s == 1) x1_valid_in = 1'b0; else x2_valid_in = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((sb.size() != 0 || busy_out) && n < bound) begin
            @(posedge system_clk); #1;
            n++;
        end
        chk("layer_complete", 64'(sb.size() == 0 && !busy_out), 64'd1);
        repeat (2) begin @(posedge system_clk); #1; end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge system_clk);
            if (x1_valid_in && x1_ready_out) acc1_tb++;
            if (x2_valid_in && x2_ready_out) acc2_tb++;
            if (prev_done) busy_after_done = busy_out;
            prev_done = 1'b0;
            if (feature_x_valid_out) begin
                rx_count++;
                if (fv < 0) begin
                    fv = cyc;
                    first_x1 = feature_x1_out;
                    first_x2 = feature_x2_out;
                end
                lv = cyc;
                $display("pair %0d cyc %0d x1=%h x2=%h done=%b", rx_count, cyc,
                         feature_x1_out, feature_x2_out, done_out);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pair: got x1=%h x2=%h expected none",
                             feature_x1_out, feature_x2_out);
                end else begin
                    e = sb.pop_front();
                    chk("pair_x1", feature_x1_out, e.a);
                    chk("pair_x2", feature_x2_out, e.b);
                    chk("pair_done", 64'(done_out), 64'(e.last));
                end
                if (done_out) begin
                    busy_at_done = busy_out;
                    prev_done = 1'b1;
                end
            end else if (!zero_ok) begin
                chk("stray_done", 64'(done_out), 64'd0);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_x1_out"}, feature_x1_out, 64'd0);
        chk({tag, "_x2_out"}, feature_x2_out, 64'd0);
        chk({tag, "_valid"}, 64'(feature_x_valid_out), 64'd0);
        chk({tag, "_x1_ready"}, 64'(x1_ready_out), 64'd0);
        chk({tag, "_x2_ready"}, 64'(x2_ready_out), 64'd0);
        chk({tag, "_busy"}, 64'(busy_out), 64'd0);
        chk({tag, "_done"}, 64'(done_out), 64'd0);
`ifdef FEATURE_ADD_PAIR_STATUS_EN
        chk({tag, "_x1_level"}, 64'(x1_level_out), 64'd0);
        chk({tag, "_x2_level"}, 64'(x2_level_out), 64'd0);
        chk({tag, "_skew_stall"}, 64'(skew_stall_out), 64'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1b;
        int rxb;
        int n;
        fork monitor(); join_none

        // Reset state
        repeat (3) @(posedge system_clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Aligned streams: 4 pairs back to back
        fv = -1;
        push_layer(4, 1);
        do_start(4);
        fork
            drive(1, 4, 0, 1, 50);
            drive(2, 4, 0, 1, 50);
        join
        wait_idle(100);
        chk("aligned_latency", 64'(fv - start_cyc), 64'd2);
        chk("aligned_back_to_back", 64'(lv - fv), 64'd3);
        chk("aligned_first_x1", first_x1, 64'hE1C1A18161412101);
        chk("aligned_first_x2", first_x2, 64'h1E3E5E7E9EBEDEFE);
        chk("aligned_busy_at_done", 64'(busy_at_done), 64'd1);
        chk("aligned_busy_after_done", 64'(busy_after_done), 64'd0);

        // Skewed: x2 starts 10 cycles late
        fv = -1;
        push_layer(8, 10);
        do_start(8);
        fork
            drive(1, 8, 0, 10, 50);
            drive(2, 8, 10, 10, 50);
        join
        wait_idle(100);
        chk("skew_first_pair_cycle", 64'(fv - start_cyc), 64'd12);

        // Overskew: x2 withheld until x1 has filled its FIFO
        a1b = acc1_tb;
        push_layer(32, 20);
        do_start(32);
        fork
            drive(1, 32, 0, 20, 300);
            drive(2, 32, 30, 20, 300);
            begin
                repeat (25) @(negedge system_clk);
                chk("overskew_x1_ready", 64'(x1_ready_out), 64'd0);
                chk("overskew_x1_accepts", 64'(acc1_tb - a1b), 64'd16);
`ifdef FEATURE_ADD_PAIR_STATUS_EN
                chk("overskew_x1_level", 64'(x1_level_out), 64'd16);
                chk("overskew_skew_stall", 64'(skew_stall_out), 64'd1);
`endif
            end
        join
        wait_idle(200);
        chk("overskew_total_x1", 64'(acc1_tb - a1b), 64'd32);

        // Surplus: 5 x1 beats offered for a 3-pair layer
        a1b = acc1_tb;
        push_layer(3, 60);
        do_start(3);
        fork
            drive(1, 5, 0, 60, 12);
            drive(2, 3, 6, 60, 50);
            begin
                repeat (5) @(negedge system_clk);
                chk("surplus_x1_ready_low", 64'(x1_ready_out), 64'd0);
                chk("surplus_x1_accepts", 64'(acc1_tb - a1b), 64'd3);
            end
        join
        wait_idle(100);
        chk("surplus_total_x1", 64'(acc1_tb - a1b), 64'd3);

        // Zero count: done in the cycle after the start edge, no pairs
        zero_ok = 1'b1;
        do_start(0);
        @(negedge system_clk);
        chk("zero_done", 64'(done_out), 64'd1);
        chk("zero_busy", 64'(busy_out), 64'd1);
        @(negedge system_clk);
        chk("zero_done_drop", 64'(done_out), 64'd0);
        chk("zero_busy_drop", 64'(busy_out), 64'd0);
        zero_ok = 1'b0;

        // Start during RUN is ignored: total stays 2
        push_layer(2, 70);
        do_start(2);
        @(posedge system_clk); #1;
        start_in = 1'b1;
        beat_count_in = CW'(5);
        @(posedge system_clk); #1;
        start_in = 1'b0;
        fork
            drive(1, 2, 0, 70, 50);
            drive(2, 2, 0, 70, 50);
        join
        wait_idle(100);

        // Reset mid-layer after 2 of 6 pairs
        push_layer(6, 80);
        rxb = rx_count;
        do_start(6);
        fork
            drive(1, 6, 0, 80, 50);
            drive(2, 6, 0, 80, 50);
            begin
                n = 0;
                while (rx_count - rxb < 2 && n < 50) begin
                    @(posedge system_clk); #1;
                    n++;
                end
                chk("midreset_two_pairs_seen", 64'(rx_count - rxb >= 2), 64'd1);
                abort = 1'b1;
                rst = 1'b1;
                @(posedge system_clk); #1;
                check_reset_outputs("midreset");
                rst = 1'b0;
                sb.delete();
            end
        join
        abort = 1'b0;

        // Fresh layer after reset: exactly 2 pairs, no stale beats
        rxb = rx_count;
        push_layer(2, 90);
        do_start(2);
        fork
            drive(1, 2, 0, 90, 50);
            drive(2, 2, 0, 90, 50);
        join
        wait_idle(100);
        chk("fresh_pair_count", 64'(rx_count - rxb), 64'd2);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
